muldiv_issue_ctrl: RTL

- Issue and hazard controller between the decode/execute stage and the HI/LO multiply-divide unit.
- Decodes the eight MIPS HI/LO funct codes, latches the operands and sequences the unit's start, write and select controls.
- Stalls the pipeline while an operation is in flight and returns MFHI/MFLO read data to writeback.
- Flags divide-by-zero and lost completions (timeout).

---
 rtl/muldiv_issue_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_issue_ctrl.sv
// Issue and hazard controller for the HI/LO multiply-divide unit: decodes HI/LO functs,
// latches operands, sequences start/write/select, interlocks HI/LO reads and flags faults.
module muldiv_issue_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Instr_Valid,
    input  logic [5:0]  Funct,
    input  logic [31:0] RsData,
    input  logic [31:0] RtData,
    output logic        Stall,
    output logic [31:0] Result,
    output logic        Result_Valid,
    output logic        DivZero,
    output logic        Err,
    output logic        MUL_Start,
    output logic        MUL_SelMD,
    output logic        MUL_SelHL,
    output logic        MUL_Write,
    output logic [31:0] MUL_DA,
    output logic [31:0] MUL_DB,
    input  logic        MUL_Flag,
    input  logic [31:0] MUL_DC
);

    localparam logic [5:0] FnMfhi  = 6'b010000;
    localparam logic [5:0] FnMthi  = 6'b010001;
    localparam logic [5:0] FnMflo  = 6'b010010;
    localparam logic [5:0] FnMtlo  = 6'b010011;
    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StSettle,
        StRead
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [31:0]       da_q, da_d;
    logic [31:0]       db_q, db_d;
    logic              sel_md_q, sel_md_d;
    logic              sel_hl_q, sel_hl_d;
    logic              err_q, err_d;
    logic [31:0]       result_q, result_d;
    logic              result_valid_q, result_valid_d;

    logic is_mf, is_mt, is_mul, is_div, dec_hi;
    logic mt_hold, accept;

    always_comb begin
        is_mf  = (Funct == FnMfhi) || (Funct == FnMflo);
        is_mt  = (Funct == FnMthi) || (Funct == FnMtlo);
        is_mul = (Funct == FnMult) || (Funct == FnMultu);
        is_div = (Funct == FnDiv)  || (Funct == FnDivu);
        dec_hi = (Funct == FnMfhi) || (Funct == FnMthi);
    end

    // An MTHI/MTLO in the Result_Valid cycle waits one cycle so MUL_Write never
    // coincides with Result_Valid.
    assign mt_hold = result_valid_q && is_mt;
    assign Stall   = Instr_Valid && ((state_q != StIdle) || mt_hold);
    assign accept  = Instr_Valid && (state_q == StIdle) && !mt_hold;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        da_d           = da_q;
        db_d           = db_q;
        sel_md_d       = sel_md_q;
        sel_hl_d       = sel_hl_q;
        err_d          = err_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        MUL_Start      = 1'b0;
        MUL_Write      = 1'b0;
        MUL_DA         = da_q;
        MUL_SelHL      = sel_hl_q;
        DivZero        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mul || is_div) begin
                        da_d     = RsData;
                        db_d     = RtData;
                        sel_md_d = is_div;
                        DivZero  = is_div && (RtData == 32'd0);
                        state_d  = StIssue;
                    end else if (is_mt) begin
                        MUL_Write = 1'b1;
                        MUL_DA    = RsData;
                        MUL_SelHL = dec_hi;
                    end else if (is_mf) begin
                        sel_hl_d  = dec_hi;
                        MUL_SelHL = dec_hi;
                        state_d   = StRead;
                    end
                end
            end
            StIssue: begin
                MUL_Start = 1'b1;
                cnt_d     = '0;
                state_d   = StWait;
            end
            StWait: begin
                cnt_d = cnt_inc;
                // A completion in the timeout cycle still counts as success.
                if (MUL_Flag) begin
                    state_d = StSettle;
                end else if (cnt_inc == TimeoutCnt) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StSettle: begin
                state_d = StIdle;
            end
            StRead: begin
                result_d       = MUL_DC;
                result_valid_d = 1'b1;
                state_d        = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            da_q           <= '0;
            db_q           <= '0;
            sel_md_q       <= 1'b0;
            sel_hl_q       <= 1'b0;
            err_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            da_q           <= da_d;
            db_q           <= db_d;
            sel_md_q       <= sel_md_d;
            sel_hl_q       <= sel_hl_d;
            err_q          <= err_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign MUL_DB       = db_q;
    assign MUL_SelMD    = sel_md_q;
    assign Err          = err_q;
    assign Result       = result_q;
    assign Result_Valid = result_valid_q;

    a_ctrl_exclusive: assert property (@(posedge Clk) disable iff (Reset)
        $onehot0({MUL_Start, MUL_Write, Result_Valid}));

endmodule
